// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types, master IDs and helpers for the SRAM arbiter
//
// Contents:
//   N_REQ / ID_W : default requester count and the matching ID width
//   req_id_t     : requester index
//   sram_tag_t   : {valid, id} entry carried down the read-tag pipeline
//   ID_*         : fixed master slots
//   next_id()    : round-robin successor with wrap at n-1
package sram_arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = $clog2(N_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } sram_tag_t;

  localparam req_id_t ID_UART = req_id_t'(0);
  localparam req_id_t ID_M1   = req_id_t'(1);
  localparam req_id_t ID_M2   = req_id_t'(2);
  localparam req_id_t ID_M3   = req_id_t'(3);

  // Successor of id in a ring of n requesters; n need not be a power of two.
  function automatic req_id_t next_id(req_id_t id, int n);
    return (int'(id) >= n - 1) ? '0 : id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner select with burst lock
//
// Ports:
//   req         in   per-master request
//   lock        in   per-master burst lock
//   ptr         in   round-robin start position
//   owner       in   master holding the burst lock
//   owner_valid in   owner field is meaningful
//   gnt         out  one-hot winner, zero when nobody requests
//   win         out  winner index (0 when none)
//   any         out  a winner exists this cycle
module rr_priority_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = N_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  req_id_t            ptr,
  input  req_id_t            owner,
  input  logic               owner_valid,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            win,
  output logic               any
);

  int      idx;
  req_id_t cand;

  always_comb begin
    gnt  = '0;
    win  = '0;
    any  = 1'b0;
    idx  = 0;
    cand = '0;
    // A locked owner that still requests keeps the port; dropping req
    // for even one cycle hands control back to the round-robin scan.
    if (owner_valid && req[owner] && lock[owner]) begin
      gnt[owner] = 1'b1;
      win        = owner;
      any        = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = req_id_t'(idx);
        if (!any && req[cand]) begin
          gnt[cand] = 1'b1;
          win       = cand;
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin SRAM port arbiter with read-response tagging
//
// Ports:
//   Clock_50, Resetn           clock, asynchronous active-low reset
//   req_i/lock_i/we_n_i        per-master request, burst lock, write enable (low)
//   addr_i/wdata_i             per-master address and write data
//   gnt_o                      one-hot combinational grant
//   rvalid_o/rdata_o           one-hot read-return strobe and shared read data
//   SRAM_address_o/...write... registered command to the SRAM controller
//   SRAM_read_data_i           read data from the SRAM controller
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ  = N_REQ,
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 18
) (
  input  logic                           Clock_50,
  input  logic                           Resetn,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             lock_i,
  input  logic [NUM_REQ-1:0]             we_n_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ-1:0][15:0]       wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [15:0]                    rdata_o,
  output logic [ADDR_W-1:0]              SRAM_address_o,
  output logic [15:0]                    SRAM_write_data_o,
  output logic                           SRAM_we_n_o,
  input  logic [15:0]                    SRAM_read_data_i
);

  // One stage per cycle between grant capture and the controller's data
  // output; the tail lines up with SRAM_read_data_i for that access.
  localparam int TAG_DEPTH = READ_LAT + 1;

  req_id_t   ptr;
  req_id_t   owner;
  logic      owner_valid;
  req_id_t   win;
  logic      any;
  sram_tag_t tag_pipe [TAG_DEPTH];
  sram_tag_t tag_tail;

  assign tag_tail = tag_pipe[TAG_DEPTH-1];

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req         (req_i),
    .lock        (lock_i),
    .ptr         (ptr),
    .owner       (owner),
    .owner_valid (owner_valid),
    .gnt         (gnt_o),
    .win         (win),
    .any         (any)
  );

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address_o    <= '0;
      SRAM_write_data_o <= '0;
      SRAM_we_n_o       <= 1'b1;
      rdata_o           <= '0;
      rvalid_o          <= '0;
      ptr               <= '0;
      owner             <= '0;
      owner_valid       <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_pipe[i] <= '0;
    end else begin
      if (any) begin
        SRAM_address_o    <= addr_i[win];
        SRAM_write_data_o <= wdata_i[win];
        SRAM_we_n_o       <= we_n_i[win];
        ptr               <= next_id(win, NUM_REQ);
        owner             <= win;
      end else begin
        // Address/data hold; only the strobe is forced inactive.
        SRAM_we_n_o <= 1'b1;
      end
      owner_valid <= any & lock_i[win];

      tag_pipe[0].valid <= any & we_n_i[win];
      tag_pipe[0].id    <= win;
      for (int i = 1; i < TAG_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];

      rvalid_o <= '0;
      if (tag_tail.valid) begin
        rvalid_o[tag_tail.id] <= 1'b1;
        rdata_o               <= SRAM_read_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a 2-cycle SRAM controller model
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 18;
  localparam int RL = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req, lock, we_n;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0][15:0]    wdata;
  logic [NR-1:0]          gnt, rvalid;
  logic [15:0]            rdata;
  logic [AW-1:0]          sram_addr;
  logic [15:0]            sram_wdata;
  logic                   sram_we_n;
  logic [15:0]            sram_rdata;

  sram_arbiter #(.NUM_REQ(NR), .READ_LAT(RL), .ADDR_W(AW)) dut (
    .Clock_50          (clk),
    .Resetn            (rst_n),
    .req_i             (req),
    .lock_i            (lock),
    .we_n_i            (we_n),
    .addr_i            (addr),
    .wdata_i           (wdata),
    .gnt_o             (gnt),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .SRAM_address_o    (sram_addr),
    .SRAM_write_data_o (sram_wdata),
    .SRAM_we_n_o       (sram_we_n),
    .SRAM_read_data_i  (sram_rdata)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM controller model: address to data in two cycles.
  bit [15:0] mem     [0:(1<<AW)-1];
  bit        written [0:(1<<AW)-1];

  function automatic logic [15:0] init_word(logic [AW-1:0] a);
    if (a == 18'h12C00) return 16'hBEEF;
    if (a == 18'h00010) return 16'hDEAD;
    if (a == 18'h00020) return 16'h3333;
    if (a >= 18'h01000 && a < 18'h01040) return 16'hA000 + 16'(a - 18'h01000);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] sram_word(logic [AW-1:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  logic [15:0] d1, d2;
  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr]     <= sram_wdata;
      written[sram_addr] <= 1'b1;
    end
    d1 <= sram_word(sram_addr);
    d2 <= d1;
  end
  assign sram_rdata = d2;

  // Scoreboard
  typedef struct {
    logic [NR-1:0] mask;
    logic [15:0]   data;
    int            due;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;
  int cnt [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rvalid != '0) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", 32'(rvalid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_owner", 32'(rvalid), 32'(e.mask));
          chk("rdata", 32'(rdata), 32'(e.data));
          chk("read_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        chk("rvalid_missing", 32'(rvalid), 32'(sb[0].mask));
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req  = '0;
    lock = '0;
    we_n = '1;
  endtask

  task automatic check_gnt(input string name, input logic [NR-1:0] exp_g);
    @(negedge clk);
    chk(name, 32'(gnt), 32'(exp_g));
  endtask

  task automatic expect_read(input logic [NR-1:0] m, input logic [15:0] d);
    sb.push_back('{mask: m, data: d, due: cyc + RL + 2});
  endtask

  task automatic check_reset_outputs();
    chk("rst_addr",   32'(sram_addr),  32'h0);
    chk("rst_wdata",  32'(sram_wdata), 32'h0);
    chk("rst_we_n",   32'(sram_we_n),  32'h1);
    chk("rst_rdata",  32'(rdata),      32'h0);
    chk("rst_rvalid", 32'(rvalid),     32'h0);
    chk("rst_gnt",    32'(gnt),        32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    addr  = '0;
    wdata = '0;
    for (int m = 0; m < NR; m++) cnt[m] = 0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;

    // Single read by M2; data returns four posedges after the grant cycle.
    req[ID_M2]  = 1'b1;
    addr[ID_M2] = 18'h12C00;
    check_gnt("t1_gnt", 4'b0100);
    expect_read(4'b0100, 16'hBEEF);
    tick();
    idle_inputs();
    check_gnt("t1_idle_gnt", 4'b0000);
    repeat (6) tick();

    // Write by M0, then read of the same word by M3 in the next cycle.
    req[ID_UART]   = 1'b1;
    we_n[ID_UART]  = 1'b0;
    addr[ID_UART]  = 18'h00010;
    wdata[ID_UART] = 16'h0005;
    check_gnt("t4_write_gnt", 4'b0001);
    tick();
    idle_inputs();
    req[ID_M3]  = 1'b1;
    addr[ID_M3] = 18'h00010;
    check_gnt("t4_read_gnt", 4'b1000);
    expect_read(4'b1000, 16'h0005);
    chk("t4_we_n_low", 32'(sram_we_n),  32'h0);
    chk("t4_waddr",    32'(sram_addr),  32'h10);
    chk("t4_wdata",    32'(sram_wdata), 32'h5);
    tick();
    idle_inputs();
    repeat (6) tick();

    // Three reads in flight, then reset: all tags must be dropped.
    req = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 18'h00100 + 18'(i);
      wdata[i] = 16'h1234;
    end
    for (int i = 0; i < 3; i++) begin
      check_gnt($sformatf("t5_gnt%0d", i), 4'(1 << i));
      tick();
    end
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'(rvalid), 32'h0);
      tick();
    end

    // All four masters read continuously; pointer restarts at 0 after reset.
    req  = '1;
    we_n = '1;
    for (int m = 0; m < NR; m++) addr[m] = 18'h01000 + 18'(m * 16);
    for (int c = 0; c < 8; c++) begin
      int m;
      m = c % NR;
      check_gnt($sformatf("t2_rr_gnt%0d", c), 4'(1 << m));
      expect_read(4'(1 << m), 16'hA000 + 16'(m * 16 + cnt[m]));
      cnt[m]++;
      tick();
      addr[m] = 18'h01000 + 18'(m * 16 + cnt[m]);
    end
    idle_inputs();
    repeat (8) tick();

    // M1 burst-locks eight writes while M3 waits for a read.
    req[ID_M1]   = 1'b1;
    lock[ID_M1]  = 1'b1;
    we_n[ID_M1]  = 1'b0;
    addr[ID_M1]  = 18'h23E00;
    wdata[ID_M1] = 16'hC000;
    req[ID_M3]   = 1'b1;
    addr[ID_M3]  = 18'h00020;
    for (int i = 0; i < 8; i++) begin
      check_gnt($sformatf("t3_lock_gnt%0d", i), 4'b0010);
      tick();
      addr[ID_M1]  = 18'h23E00 + 18'(i + 1);
      wdata[ID_M1] = 16'hC000 + 16'(i + 1);
    end
    req[ID_M1]  = 1'b0;
    lock[ID_M1] = 1'b0;
    check_gnt("t3_m3_gnt", 4'b1000);
    expect_read(4'b1000, 16'h3333);
    tick();
    idle_inputs();
    repeat (6) tick();
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_sram_word%0d", i), 32'(sram_word(18'h23E00 + 18'(i))), 32'hC000 + 32'(i));

    // Idle: no grants and no write strobe.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_we_n", 32'(sram_we_n), 32'h1);
      chk("t6_gnt",  32'(gnt),       32'h0);
      tick();
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port (through the existing SRAM controller) between up to NUM_REQ on-chip masters: UART loader, upsample/colour-convert unit, IDCT unit, lossless decoder.
- Round-robin arbitration, one access per cycle, with an optional burst lock.
- Tags read responses through a pipeline so each read word is returned only to the master that issued it.
- Sits between the top-level FSM's masters and the SRAM controller instance in project.

Parameters:
- NUM_REQ, 4: number of requesters; ID width is clog2(NUM_REQ).
- READ_LAT, 2: cycles from the address at the SRAM controller input to valid read data at its output.
- ADDR_W, 18: SRAM word-address width.

Ports:
- Clock_50  in  1  system clock; all logic on posedge.
- Resetn  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  access request per master; held until granted.
- lock_i  in  NUM_REQ  burst lock per master; keeps the grant while high.
- we_n_i  in  NUM_REQ  per-master write enable, active low.
- addr_i  in  NUM_REQ x ADDR_W  per-master address.
- wdata_i  in  NUM_REQ x 16  per-master write data.
- gnt_o  out  NUM_REQ  one-hot, combinational; access accepted this cycle.
- rvalid_o  out  NUM_REQ  one-hot; read data is for this master.
- rdata_o  out  16  read data, shared by all masters.
- SRAM_address_o  out  ADDR_W  to SRAM controller.
- SRAM_write_data_o  out  16  to SRAM controller.
- SRAM_we_n_o  out  1  to SRAM controller.
- SRAM_read_data_i  in  16  from SRAM controller.

Behaviour:
- Reset values (asynchronous):
  - SRAM_address_o=0, SRAM_write_data_o=0, SRAM_we_n_o=1, rdata_o=0, rvalid_o=0.
  - RR pointer=0, owner=none, tag pipeline cleared.
- Arbitration (combinational, each cycle):
  - If owner is valid and req_i[owner] & lock_i[owner]: the owner wins.
  - Otherwise, scan from RR pointer upward, mod NUM_REQ; the first set req_i wins.
  - gnt_o = one-hot of the winner; all zeros if no req.
  - At most one bit of gnt_o is ever set.
- On a granted cycle, at posedge:
  - SRAM_address_o <= addr_i[w]; SRAM_write_data_o <= wdata_i[w]; SRAM_we_n_o <= we_n_i[w].
  - RR pointer <= (w+1) mod NUM_REQ.
  - owner <= w if lock_i[w], else none.
- Idle cycle: SRAM_we_n_o <= 1. Address and write data hold their last values, so there are no spurious writes.
- Lock behaviour:
  - A locked owner keeps the grant every cycle it requests.
  - If the owner drops req_i for a cycle while lock_i stays high, it loses ownership. Normal round-robin resumes that cycle.
  - lock_i from a non-owner only takes effect once that master wins.
- Read tagging:
  - Shift register of depth READ_LAT+1, entries {valid, id}.
  - Entry pushed each cycle: valid = granted & we_n_i[w], id = w.
  - rvalid_o[id] and rdata_o are registered together from the pipe tail and SRAM_read_data_i.
  - Read latency seen by a master: data and rvalid arrive READ_LAT+2 posedges after the gnt cycle's posedge (default 4).
  - Writes produce no rvalid.
  - Back-to-back reads from mixed masters return in issue order, one per cycle.
- Master contract: hold req/addr/we_n/wdata stable until gnt is seen. The arbiter accepts a new request every cycle; there is no backpressure.
- Reset mid-operation: in-flight tags are discarded; no rvalid after Resetn rises until a new read is granted.
- Pointer wrap: pointer value NUM_REQ-1 plus a grant wraps to 0.

Decomposition:
- Shared package sram_arb_pkg:
  - typedef req_id_t (clog2 NUM_REQ bits).
  - typedef sram_tag_t {valid, id}.
  - Constants for master IDs: ID_UART=0, ID_M1=1, ID_M2=2, ID_M3=3.
- One natural sub-module, rr_priority_pick: combinational round-robin picker taking req, pointer, owner and lock, producing a one-hot winner. The tag pipeline stays in the parent.

Test Plan:
- Single master: M2 reads address 0x12C00 with SRAM pre-loaded with 0xBEEF → gnt_o=4'b0100 the same cycle; rvalid_o=4'b0100 and rdata_o=0xBEEF exactly 4 posedges later; no other rvalid.
- All four masters request reads continuously from pointer 0 → grants cycle 0,1,2,3,0…; each rvalid returns the address-tagged data to the matching master in order, one per cycle.
- M1 locks and issues 8 writes to 0x23E00–0x23E07 while M3 requests → M3 is not granted until after M1's 8th grant; M3 is granted the cycle after M1 drops lock; SRAM holds all 8 words.
- Interleaved write (M0 writes 0x0005 to 0x00010) then read of the same address by M3 the next cycle → M3 receives 0x0005; no rvalid is raised for M0.
- Resetn pulled low for 2 cycles with 3 reads in flight → all outputs at reset values; zero rvalid afterwards until a new read is granted; pointer restarts at 0.
- Idle for 10 cycles after activity → SRAM_we_n_o stays 1 and gnt_o=0 throughout.
